// File: rtl/imem_lsu_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter: FSM states, owner ids, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/imem_lsu_port_arbiter_if.sv
// Bundle of fetch, LSU and memory-port signals around the arbiter.
// Handshake: req is a level held until a 1-cycle gnt pulse; each grant yields exactly one
// 1-cycle rvalid pulse; mem_req is held until mem_valid, which carries mem_rdata that cycle.
interface imem_lsu_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [BE_W-1:0]   ls_be_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_valid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              spurious_o;

  // Arbiter side.
  modport master (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_valid_i, mem_rdata_i,
    output spurious_o
  );

  // Requesters and memory side.
  modport slave (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_valid_i, mem_rdata_i,
    input  spurious_o
  );
endinterface

// File: rtl/imem_lsu_port_arbiter_pick.sv
// Combinational 2-way owner picker. MEM_ARB_RR_EN defined: round-robin against last_owner;
// undefined: fixed priority with the LSU winning.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  owner_e last_owner,
`endif
  input  logic   if_req,
  input  logic   ls_req,
  output owner_e owner
);

  always_comb begin
    owner = OWN_IF;
    if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
      owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
`else
      owner = OWN_LS;
`endif
    end else if (ls_req) begin
      owner = OWN_LS;
    end
  end

endmodule

// File: rtl/imem_lsu_port_arbiter.sv
// Non-pipelined arbiter sharing one memory port between fetch and LSU; one transaction in flight.
// MEM_ARB_RR_EN selects round-robin arbitration on simultaneous requests (default: LSU priority).
module imem_lsu_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  imem_lsu_port_arbiter_if.master bus,
  output state_e state_o
);
  localparam int BE_W = DATA_W / 8;

  state_e state_q, state_d;
  owner_e pick_owner;
  logic   if_gnt, ls_gnt, grant, done;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              if_rvalid_q, ls_rvalid_q, spurious_q, drop_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      last_owner_q <= OWN_IF;
    else if (grant) last_owner_q <= pick_owner;
  end
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .if_req     (bus.if_req_i),
    .ls_req     (bus.ls_req_i),
    .owner      (pick_owner)
  );

  assign grant = if_gnt | ls_gnt;
  assign done  = (state_q != IDLE) && bus.mem_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.ls_req_i) begin
          if (pick_owner == OWN_LS) begin
            ls_gnt  = 1'b1;
            state_d = BUSY_LS;
          end else begin
            if_gnt  = 1'b1;
            state_d = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_LS: if (bus.mem_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      spurious_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (grant)     mem_req_q <= 1'b1;
      else if (done) mem_req_q <= 1'b0;

      if (if_gnt) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr_i;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end else if (ls_gnt) begin
        mem_we_q    <= bus.ls_we_i;
        mem_addr_q  <= bus.ls_addr_i;
        mem_wdata_q <= bus.ls_wdata_i;
        mem_be_q    <= bus.ls_be_i;
      end

      // A flush seen before or alongside completion silences the fetch response.
      if_rvalid_q <= (state_q == BUSY_IF) && bus.mem_valid_i && !(drop_q || bus.if_flush_i);
      if ((state_q == BUSY_IF) && bus.mem_valid_i && !(drop_q || bus.if_flush_i))
        if_rdata_q <= bus.mem_rdata_i;

      ls_rvalid_q <= (state_q == BUSY_LS) && bus.mem_valid_i;
      if ((state_q == BUSY_LS) && bus.mem_valid_i)
        ls_rdata_q <= mem_we_q ? '0 : bus.mem_rdata_i;

      if (state_q == BUSY_IF && !bus.mem_valid_i && bus.if_flush_i) drop_q <= 1'b1;
      else if (state_q != BUSY_IF || bus.mem_valid_i)               drop_q <= 1'b0;

      spurious_q <= (state_q == IDLE) && bus.mem_valid_i;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.spurious_o  = spurious_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_imem_lsu_port_arbiter.sv
// Directed bench for imem_lsu_port_arbiter: inputs driven at the falling edge, outputs checked 1ns later.
module tb_imem_lsu_port_arbiter;
  import mem_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e state_dbg;
  int     checks = 0;
  int     errors = 0;
  logic [15:0] last_if_data;

  imem_lsu_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  imem_lsu_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
    bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0; bus.ls_be_i = '0;
    bus.mem_valid_i = 0; bus.mem_rdata_i = '0;

    // Reset state
    next_cycle(); next_cycle(); settle();
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_mem_req", 32'(bus.mem_req_o), 0);
    chk("rst_rvalid", {bus.if_rvalid_o, bus.ls_rvalid_o, bus.spurious_o}, 0);
    chk("rst_rdata", {bus.if_rdata_o, bus.ls_rdata_o}, 0);
    next_cycle(); rst = 0;

    // 1. Fetch only
    next_cycle(); bus.if_req_i = 1; bus.if_addr_i = 16'h0002; settle();
    chk("t1_if_gnt", 32'(bus.if_gnt_o), 1);
    chk("t1_mem_req_n", 32'(bus.mem_req_o), 0);
    next_cycle(); bus.if_req_i = 0; settle();
    chk("t1_mem_req", 32'(bus.mem_req_o), 1);
    chk("t1_mem_addr", 32'(bus.mem_addr_o), 32'h0002);
    chk("t1_mem_we_be", {bus.mem_we_o, bus.mem_be_o}, 3'b011);
    chk("t1_state", 32'(state_dbg), 32'(BUSY_IF));
    chk("t1_if_gnt_busy", 32'(bus.if_gnt_o), 0);
    next_cycle(); settle();
    chk("t1_mem_req_hold", 32'(bus.mem_req_o), 1);
    next_cycle(); bus.mem_valid_i = 1; bus.mem_rdata_i = 16'hA55A; settle();
    chk("t1_rvalid_early", 32'(bus.if_rvalid_o), 0);
    next_cycle(); bus.mem_valid_i = 0; bus.mem_rdata_i = 16'h0000; settle();
    chk("t1_if_rvalid", 32'(bus.if_rvalid_o), 1);
    chk("t1_if_rdata", 32'(bus.if_rdata_o), 32'hA55A);
    chk("t1_ls_rvalid", 32'(bus.ls_rvalid_o), 0);
    chk("t1_mem_req_drop", 32'(bus.mem_req_o), 0);
    chk("t1_state_idle", 32'(state_dbg), 32'(IDLE));
    next_cycle(); settle();
    chk("t1_rvalid_pulse", 32'(bus.if_rvalid_o), 0);
    chk("t1_rdata_hold", 32'(bus.if_rdata_o), 32'hA55A);

    // 2. LSU store
    next_cycle();
    bus.ls_req_i = 1; bus.ls_we_i = 1; bus.ls_addr_i = 16'h4000; bus.ls_wdata_i = 16'hBEEF; bus.ls_be_i = 2'b01;
    settle();
    chk("t2_ls_gnt", 32'(bus.ls_gnt_o), 1);
    next_cycle(); bus.ls_req_i = 0; settle();
    chk("t2_mem_req", 32'(bus.mem_req_o), 1);
    chk("t2_mem_we_be", {bus.mem_we_o, bus.mem_be_o}, 3'b101);
    chk("t2_mem_addr", 32'(bus.mem_addr_o), 32'h4000);
    chk("t2_mem_wdata", 32'(bus.mem_wdata_o), 32'hBEEF);
    next_cycle(); bus.mem_valid_i = 1; bus.mem_rdata_i = 16'h1234; settle();
    next_cycle(); bus.mem_valid_i = 0; settle();
    chk("t2_ls_rvalid", 32'(bus.ls_rvalid_o), 1);
    chk("t2_ls_rdata", 32'(bus.ls_rdata_o), 0);
    chk("t2_if_rvalid", 32'(bus.if_rvalid_o), 0);

    // 3. Simultaneous requests, four each side, after a fresh reset
    next_cycle(); rst = 1; next_cycle(); rst = 0;
    next_cycle();
    bus.if_req_i = 1; bus.if_addr_i = 16'h0100;
    bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_addr_i = 16'h8000; bus.ls_be_i = 2'b11;
    settle();
    begin
      int if_cnt = 0;
      int ls_cnt = 0;
      for (int g = 0; g < 8; g++) begin
        logic exp_ls;
`ifdef MEM_ARB_RR_EN
        exp_ls = (g % 2 == 0);
`else
        exp_ls = (g < 4);
`endif
        chk($sformatf("t3_ls_gnt_%0d", g), 32'(bus.ls_gnt_o), 32'(exp_ls));
        chk($sformatf("t3_if_gnt_%0d", g), 32'(bus.if_gnt_o), 32'(!exp_ls));
        next_cycle();
        if (exp_ls) begin ls_cnt++; if (ls_cnt == 4) bus.ls_req_i = 0; end
        else        begin if_cnt++; if (if_cnt == 4) bus.if_req_i = 0; end
        bus.mem_valid_i = 1; bus.mem_rdata_i = 16'hC000 + 16'(g);
        settle();
        chk($sformatf("t3_mem_req_%0d", g), 32'(bus.mem_req_o), 1);
        chk($sformatf("t3_mem_addr_%0d", g), 32'(bus.mem_addr_o), exp_ls ? 32'h8000 : 32'h0100);
        next_cycle(); bus.mem_valid_i = 0; settle();
        chk($sformatf("t3_ls_rvalid_%0d", g), 32'(bus.ls_rvalid_o), 32'(exp_ls));
        chk($sformatf("t3_if_rvalid_%0d", g), 32'(bus.if_rvalid_o), 32'(!exp_ls));
        if (exp_ls) chk($sformatf("t3_ls_rdata_%0d", g), 32'(bus.ls_rdata_o), 32'hC000 + g);
        else        chk($sformatf("t3_if_rdata_%0d", g), 32'(bus.if_rdata_o), 32'hC000 + g);
      end
    end
    last_if_data = 16'hC007;

    // 4. Flush of an in-flight fetch; pending LSU load waits, then is granted
    next_cycle(); bus.if_req_i = 1; bus.if_addr_i = 16'h1000; settle();
    chk("t4_if_gnt", 32'(bus.if_gnt_o), 1);
    next_cycle(); bus.if_req_i = 0; bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_addr_i = 16'h2000; settle();
    chk("t4_ls_gnt_busy", 32'(bus.ls_gnt_o), 0);
    chk("t4_mem_addr", 32'(bus.mem_addr_o), 32'h1000);
    next_cycle(); bus.if_flush_i = 1; settle();
    next_cycle(); bus.if_flush_i = 0; bus.mem_valid_i = 1; bus.mem_rdata_i = 16'hDEAD; settle();
    chk("t4_ls_gnt_busy2", 32'(bus.ls_gnt_o), 0);
    next_cycle(); bus.mem_valid_i = 0; settle();
    chk("t4_if_rvalid_dropped", 32'(bus.if_rvalid_o), 0);
    chk("t4_if_rdata_hold", 32'(bus.if_rdata_o), 32'(last_if_data));
    chk("t4_ls_gnt", 32'(bus.ls_gnt_o), 1);
    next_cycle(); bus.ls_req_i = 0; bus.mem_valid_i = 1; bus.mem_rdata_i = 16'h5555; settle();
    chk("t4_ls_mem_addr", 32'(bus.mem_addr_o), 32'h2000);
    next_cycle(); bus.mem_valid_i = 0; settle();
    chk("t4_ls_rvalid", 32'(bus.ls_rvalid_o), 1);
    chk("t4_ls_rdata", 32'(bus.ls_rdata_o), 32'h5555);

    // 4b. Flush in the same cycle as completion
    next_cycle(); bus.if_req_i = 1; bus.if_addr_i = 16'h1002; settle();
    next_cycle(); bus.if_req_i = 0; bus.mem_valid_i = 1; bus.mem_rdata_i = 16'hBAD0; bus.if_flush_i = 1; settle();
    next_cycle(); bus.mem_valid_i = 0; bus.if_flush_i = 0; settle();
    chk("t4b_if_rvalid_dropped", 32'(bus.if_rvalid_o), 0);
    chk("t4b_if_rdata_hold", 32'(bus.if_rdata_o), 32'(last_if_data));

    // 5. Spurious completion while idle
    next_cycle(); bus.mem_valid_i = 1; settle();
    chk("t5_spurious_early", 32'(bus.spurious_o), 0);
    next_cycle(); bus.mem_valid_i = 0; settle();
    chk("t5_spurious", 32'(bus.spurious_o), 1);
    chk("t5_no_rvalid", {bus.if_rvalid_o, bus.ls_rvalid_o}, 0);
    next_cycle(); settle();
    chk("t5_spurious_pulse", 32'(bus.spurious_o), 0);

    // 6. Reset while BUSY_LS
    next_cycle(); bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_addr_i = 16'h3000; settle();
    chk("t6_ls_gnt", 32'(bus.ls_gnt_o), 1);
    next_cycle(); bus.ls_req_i = 0; settle();
    chk("t6_state_busy", 32'(state_dbg), 32'(BUSY_LS));
    rst = 1; settle();
    chk("t6_mem_req_async", 32'(bus.mem_req_o), 0);
    chk("t6_state_idle", 32'(state_dbg), 32'(IDLE));
    next_cycle(); rst = 0;
    next_cycle(); bus.mem_valid_i = 1; bus.mem_rdata_i = 16'h7777; settle();
    next_cycle(); bus.mem_valid_i = 0; settle();
    chk("t6_spurious", 32'(bus.spurious_o), 1);
    chk("t6_no_rvalid", {bus.if_rvalid_o, bus.ls_rvalid_o}, 0);
    chk("t6_ls_rdata_reset", 32'(bus.ls_rdata_o), 0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
